// File: rtl/axi_weight_write_scheduler_pkg.sv
// Shared constants, FIFO entry layout and FSM encoding for the weight write scheduler.
package axi_weight_write_scheduler_pkg;

   localparam int NUM_WEIGHTS       = 76976;
   localparam int AXI_BASE_ADDR     = (512*256*3)+(32*64/4)+4;
   localparam int WEIGHT_ADDR_WIDTH = 17;

   // One accepted 32-bit beat: word index plus which 16-bit halves carry a weight.
   typedef struct packed {
      logic [WEIGHT_ADDR_WIDTH-2:0] word;
      logic [31:0]                  data;
      logic                         vlo;
      logic                         vhi;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } state_t;

endpackage

// File: rtl/weight_wr_fifo.sv
// Small synchronous FIFO holding accepted AXI beats until the write port is free.
module weight_wr_fifo #(
   parameter int DATA_W = 50,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       cnt;

   // Pointer and occupancy bookkeeping; simultaneous push and pop keeps occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage array; contents are don't-care while empty so it carries no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign count = cnt;

endmodule

// File: rtl/axi_weight_write_scheduler.sv
// Serialises AXI-Lite weight beats onto the 16-bit weight-memory write port,
// runs the zero-fill clear engine and tracks load progress.
module axi_weight_write_scheduler
   import axi_weight_write_scheduler_pkg::*;
#(
   parameter int NUM_WEIGHTS    = axi_weight_write_scheduler_pkg::NUM_WEIGHTS,
   parameter int AXI_BASE_ADDR  = axi_weight_write_scheduler_pkg::AXI_BASE_ADDR,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  axi_wr_data,
   input  logic [AXI_ADDR_WIDTH-1:0]    axi_wr_addr,
   input  logic [3:0]                   axi_wr_strobe,
   input  logic                         axi_wr_en,
   output logic                         axi_wr_ready,
   input  logic                         clear_start,
   output logic                         clear_busy,
   output logic [15:0]                  weight_wr_data,
   output logic [WEIGHT_ADDR_WIDTH-1:0] weight_wr_addr,
   output logic                         weight_wr_en,
   output logic [WEIGHT_ADDR_WIDTH:0]   weight_count,
   output logic                         weights_loaded
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [AXI_ADDR_WIDTH-1:0]    BASE_A   = AXI_ADDR_WIDTH'(AXI_BASE_ADDR);
   localparam logic [AXI_ADDR_WIDTH-1:0]    SPAN_A   = AXI_ADDR_WIDTH'(2*NUM_WEIGHTS);
   localparam logic [WEIGHT_ADDR_WIDTH-1:0] NUM_IDX  = WEIGHT_ADDR_WIDTH'(NUM_WEIGHTS);
   localparam logic [WEIGHT_ADDR_WIDTH-1:0] LAST_IDX = WEIGHT_ADDR_WIDTH'(NUM_WEIGHTS-1);
   localparam logic [WEIGHT_ADDR_WIDTH:0]   NUM_CNT  = (WEIGHT_ADDR_WIDTH+1)'(NUM_WEIGHTS);
   localparam logic [WEIGHT_ADDR_WIDTH:0]   CNT_LAST = (WEIGHT_ADDR_WIDTH+1)'(NUM_WEIGHTS-1);

   logic [AXI_ADDR_WIDTH-1:0]    off;
   logic                         in_range, vlo, vhi, accept, push, pop;
   fifo_entry_t                  push_entry, head;
   logic                         fifo_full, fifo_empty;
   logic [CNT_W-1:0]             fifo_count;
   state_t                       state_q, state_d;
   logic                         half_q, half_d, take_lo;
   logic [WEIGHT_ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d, idx;
   logic                         clr_done, clear_busy_q;
   logic                         iss_en, iss_axi;
   logic [WEIGHT_ADDR_WIDTH-1:0] iss_addr;
   logic [15:0]                  iss_data;
   logic                         vld_p0;
   logic [WEIGHT_ADDR_WIDTH-1:0] addr_p0;
   logic [15:0]                  data_p0;
   logic [WEIGHT_ADDR_WIDTH:0]   count_q;
   logic                         loaded_q;

   // Beat decode: byte offset from weight 0, range test and half-word validity.
   assign off          = axi_wr_addr - BASE_A;
   assign in_range     = (axi_wr_addr >= BASE_A) && (off < SPAN_A);
   assign vlo          = (axi_wr_strobe[1:0] == 2'b11);
   assign vhi          = (axi_wr_strobe[3:2] == 2'b11);
   assign axi_wr_ready = ~fifo_full & ~clear_busy_q & ~rst;
   assign accept       = axi_wr_en & axi_wr_ready;
   assign push         = accept & in_range & (vlo | vhi);
   assign push_entry   = '{word: off[WEIGHT_ADDR_WIDTH:2], data: axi_wr_data, vlo: vlo, vhi: vhi};

   weight_wr_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Even half goes first when present; the odd half follows on the next cycle.
   assign take_lo = head.vlo & ~half_q;
   assign idx     = {head.word, ~take_lo};

   // Next-state and write-issue decisions for the drain/clear sequencer.
   always_comb begin
      state_d   = state_q;
      half_d    = half_q;
      clr_idx_d = clr_idx_q;
      clr_done  = 1'b0;
      pop       = 1'b0;
      iss_en    = 1'b0;
      iss_axi   = 1'b0;
      iss_addr  = addr_p0;
      iss_data  = data_p0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d = DRAIN;
               half_d  = 1'b0;
            end else if (clear_busy_q) begin
               state_d   = CLEAR;
               clr_idx_d = '0;
            end
         end
         DRAIN: begin
            iss_addr = idx;
            iss_data = take_lo ? head.data[15:0] : head.data[31:16];
            iss_en   = (idx < NUM_IDX);
            iss_axi  = iss_en;
            if (take_lo && head.vhi) begin
               half_d = 1'b1;
            end else begin
               pop     = 1'b1;
               half_d  = 1'b0;
               // Continue straight into the next entry when one remains after this pop.
               state_d = ((fifo_count > CNT_W'(1)) || push) ? DRAIN : IDLE;
            end
         end
         CLEAR: begin
            iss_en   = 1'b1;
            iss_addr = clr_idx_q;
            iss_data = 16'h0000;
            if (clr_idx_q == LAST_IDX) begin
               clr_done = 1'b1;
               state_d  = IDLE;
            end else begin
               clr_idx_d = clr_idx_q + WEIGHT_ADDR_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state, clear request latch and progress counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         half_q       <= 1'b0;
         clr_idx_q    <= '0;
         clear_busy_q <= 1'b0;
         count_q      <= '0;
         loaded_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         half_q    <= half_d;
         clr_idx_q <= clr_idx_d;
         if (clr_done)         clear_busy_q <= 1'b0;
         else if (clear_start) clear_busy_q <= 1'b1;
         if (clr_done) begin
            count_q  <= '0;
            loaded_q <= 1'b0;
         end else if (iss_axi && (count_q != NUM_CNT)) begin
            count_q  <= count_q + (WEIGHT_ADDR_WIDTH+1)'(1);
            loaded_q <= (count_q == CNT_LAST);
         end
      end
   end

   // Stage p0: registered write port; address and data hold when no write issues.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         addr_p0 <= '0;
         data_p0 <= '0;
      end else begin
         vld_p0 <= iss_en;
         if (iss_en) begin
            addr_p0 <= iss_addr;
            data_p0 <= iss_data;
         end
      end
   end

   assign weight_wr_en   = vld_p0;
   assign weight_wr_addr = addr_p0;
   assign weight_wr_data = data_p0;
   assign clear_busy     = clear_busy_q;
   assign weight_count   = count_q;
   assign weights_loaded = loaded_q;

endmodule

// File: tb/tb_axi_weight_write_scheduler.sv
// Directed bench for axi_weight_write_scheduler with a reduced weight count.
module tb_axi_weight_write_scheduler;

   localparam int N    = 128;
   localparam int BASE = (512*256*3)+(32*64/4)+4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] axi_wr_data = '0;
   logic [31:0] axi_wr_addr = '0;
   logic [3:0]  axi_wr_strobe = '0;
   logic        axi_wr_en = 1'b0;
   logic        axi_wr_ready;
   logic        clear_start = 1'b0;
   logic        clear_busy;
   logic [15:0] weight_wr_data;
   logic [16:0] weight_wr_addr;
   logic        weight_wr_en;
   logic [17:0] weight_count;
   logic        weights_loaded;

   axi_weight_write_scheduler #(.NUM_WEIGHTS(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .axi_wr_data    (axi_wr_data),
      .axi_wr_addr    (axi_wr_addr),
      .axi_wr_strobe  (axi_wr_strobe),
      .axi_wr_en      (axi_wr_en),
      .axi_wr_ready   (axi_wr_ready),
      .clear_start    (clear_start),
      .clear_busy     (clear_busy),
      .weight_wr_data (weight_wr_data),
      .weight_wr_addr (weight_wr_addr),
      .weight_wr_en   (weight_wr_en),
      .weight_count   (weight_count),
      .weights_loaded (weights_loaded)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [16:0] wa[$];
   logic [15:0] wd[$];
   int          wc[$];
   always @(negedge clk) begin
      if (weight_wr_en === 1'b1) begin
         wa.push_back(weight_wr_addr);
         wd.push_back(weight_wr_data);
         wc.push_back(cyc);
      end
   end

   int n_vec = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clrq();
      wa.delete();
      wd.delete();
      wc.delete();
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output int acc, output bit saw_low);
      int g = 0;
      saw_low = 1'b0;
      axi_wr_addr = a;
      axi_wr_data = d;
      axi_wr_strobe = s;
      axi_wr_en = 1'b1;
      while (!axi_wr_ready && g < 200) begin
         saw_low = 1'b1;
         step();
         g++;
      end
      if (g >= 200) begin
         n_vec++;
         n_fail++;
         $display("FAIL send timeout: ready got %0b expected 1", axi_wr_ready);
      end
      step();
      acc = cyc;
      axi_wr_en = 1'b0;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          nw;
      logic [16:0] i0;
      logic [15:0] d0;
      logic [16:0] i1;
      logic [15:0] d1;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int acc, g, bad;
      bit low, any_low;

      tbl[0] = '{BASE+8,     32'hBEEF_1234, 4'hF, 2, 17'd4,     16'h1234, 17'd5,     16'hBEEF};
      tbl[1] = '{BASE+0,     32'h5A5A_A5A5, 4'h3, 1, 17'd0,     16'hA5A5, 17'd0,     16'h0000};
      tbl[2] = '{BASE+4,     32'hC0DE_0077, 4'hC, 1, 17'd3,     16'hC0DE, 17'd0,     16'h0000};
      tbl[3] = '{BASE+12,    32'h1111_2222, 4'h1, 0, 17'd0,     16'h0000, 17'd0,     16'h0000};
      tbl[4] = '{BASE-4,     32'hDEAD_BEEF, 4'hF, 0, 17'd0,     16'h0000, 17'd0,     16'h0000};
      tbl[5] = '{BASE+2*N-4, 32'h7777_6666, 4'hF, 2, 17'(N-2), 16'h6666, 17'(N-1), 16'h7777};
      tbl[6] = '{BASE+2*N,   32'h1234_5678, 4'hF, 0, 17'd0,     16'h0000, 17'd0,     16'h0000};
      tbl[7] = '{BASE+16,    32'h9999_8888, 4'h6, 0, 17'd0,     16'h0000, 17'd0,     16'h0000};
      tbl[8] = '{BASE+20,    32'hABCD_0123, 4'hE, 1, 17'd11,    16'hABCD, 17'd0,     16'h0000};

      // Reset state
      repeat (3) step();
      chk("rst ready", axi_wr_ready, 0);
      chk("rst clear_busy", clear_busy, 0);
      chk("rst wr_en", weight_wr_en, 0);
      chk("rst wr_addr", weight_wr_addr, 0);
      chk("rst wr_data", weight_wr_data, 0);
      chk("rst count", weight_count, 0);
      chk("rst loaded", weights_loaded, 0);
      rst = 1'b0;
      #1;
      chk("ready after rst", axi_wr_ready, 1);

      // Single beats: decode, half strobes, range edges, latency
      for (int i = 0; i < 9; i++) begin
         clrq();
         send(tbl[i].addr, tbl[i].data, tbl[i].strb, acc, low);
         repeat (8) step();
         chk($sformatf("v%0d writes", i), wa.size(), tbl[i].nw);
         if (tbl[i].nw > 0 && wa.size() > 0) begin
            chk($sformatf("v%0d addr0", i), wa[0], tbl[i].i0);
            chk($sformatf("v%0d data0", i), wd[0], tbl[i].d0);
            chk($sformatf("v%0d latency", i), wc[0] - acc, 2);
         end
         if (tbl[i].nw > 1 && wa.size() > 1) begin
            chk($sformatf("v%0d addr1", i), wa[1], tbl[i].i1);
            chk($sformatf("v%0d data1", i), wd[1], tbl[i].d1);
            chk($sformatf("v%0d gap", i), wc[1] - wc[0], 1);
         end
      end
      chk("count after table", weight_count, 7);

      // Backpressure: 8 back-to-back full beats into a 4-deep FIFO
      clrq();
      any_low = 1'b0;
      for (int k = 0; k < 8; k++) begin
         send(BASE + 4*k, {16'(16'hA000 + 2*k + 1), 16'(16'hA000 + 2*k)}, 4'hF, acc, low);
         any_low |= low;
      end
      repeat (30) step();
      chk("bp ready dropped", any_low, 1);
      chk("bp ready recovered", axi_wr_ready, 1);
      chk("bp writes", wa.size(), 16);
      bad = 0;
      for (int i = 0; i < 16 && i < wa.size(); i++) begin
         if (wa[i] !== 17'(i) || wd[i] !== 16'(16'hA000 + i) || wc[i] !== wc[0] + i) bad++;
      end
      chk("bp order/bubbles", bad, 0);
      chk("bp count", weight_count, 23);

      // Load all weights from a fresh reset, then saturate
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("count cleared by rst", weight_count, 0);
      clrq();
      for (int k = 0; k < N/2 - 1; k++)
         send(BASE + 4*k, {16'(2*k + 1), 16'(2*k)}, 4'hF, acc, low);
      repeat (8) step();
      chk("almost loaded count", weight_count, N - 2);
      chk("almost loaded flag", weights_loaded, 0);
      send(BASE + 2*N - 4, 32'h0001_0002, 4'hF, acc, low);
      repeat (8) step();
      chk("load writes", wa.size(), N);
      chk("loaded count", weight_count, N);
      chk("loaded flag", weights_loaded, 1);
      send(BASE + 8, 32'h0003_0004, 4'hF, acc, low);
      repeat (8) step();
      chk("count saturates", weight_count, N);
      chk("loaded holds", weights_loaded, 1);

      // Clear requested with beats still queued
      clrq();
      send(BASE + 40, 32'h1111_2222, 4'hF, acc, low);
      send(BASE + 44, 32'h3333_4444, 4'hF, acc, low);
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      chk("clear busy set", clear_busy, 1);
      chk("clear blocks ready", axi_wr_ready, 0);
      repeat (50) step();
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      g = 0;
      while (clear_busy && g < 2000) begin
         step();
         g++;
      end
      chk("clear finished", clear_busy, 0);
      repeat (4) step();
      chk("clear writes", wa.size(), N + 4);
      if (wa.size() >= 4) begin
         chk("queued w0", {wa[0], wd[0]}, {17'd20, 16'h2222});
         chk("queued w1", {wa[1], wd[1]}, {17'd21, 16'h1111});
         chk("queued w2", {wa[2], wd[2]}, {17'd22, 16'h4444});
         chk("queued w3", {wa[3], wd[3]}, {17'd23, 16'h3333});
      end
      bad = 0;
      for (int i = 0; i < N && i + 4 < wa.size(); i++)
         if (wa[i+4] !== 17'(i) || wd[i+4] !== 16'h0000) bad++;
      chk("zero-fill entries", bad, 0);
      chk("count after clear", weight_count, 0);
      chk("loaded after clear", weights_loaded, 0);
      chk("ready after clear", axi_wr_ready, 1);

      // Reset in the middle of a clear
      clrq();
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      g = 0;
      while (!(weight_wr_en && weight_wr_addr == 17'd99) && g < 500) begin
         step();
         g++;
      end
      chk("clear reached 99", weight_wr_addr, 99);
      rst = 1'b1;
      #1;
      chk("mid-clear rst ready", axi_wr_ready, 0);
      step();
      chk("mid-clear rst wr_en", weight_wr_en, 0);
      chk("mid-clear rst busy", clear_busy, 0);
      chk("mid-clear rst ready held", axi_wr_ready, 0);
      clrq();
      rst = 1'b0;
      #1;
      chk("ready after mid-clear rst", axi_wr_ready, 1);
      repeat (6) step();
      chk("no writes after rst", wa.size(), 0);
      send(BASE + 8, 32'hBEEF_1234, 4'hF, acc, low);
      repeat (8) step();
      chk("post-rst writes", wa.size(), 2);
      if (wa.size() > 0) chk("post-rst first", {wa[0], wd[0]}, {17'd4, 16'h1234});
      chk("post-rst count", weight_count, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
